// File: rtl/mq_fifo_pkg.sv
// Shared helpers for the multi-queue FIFO: width derivation and per-queue status predicates.
package mq_fifo_pkg;

    // Queue-id width; a single queue still gets a 1-bit id port.
    function automatic int unsigned calc_qw(input int unsigned num_queues);
        return (num_queues > 2) ? $clog2(num_queues) : 1;
    endfunction

    function automatic int unsigned calc_pw(input int unsigned queue_size);
        return $clog2(queue_size);
    endfunction

    // Count needs one extra bit so a completely full queue is representable.
    function automatic int unsigned calc_cw(input int unsigned queue_size);
        return $clog2(queue_size) + 1;
    endfunction

    function automatic logic thresh_reached(input int unsigned count,
                                            input int unsigned thresh);
        return count >= thresh;
    endfunction

    function automatic logic is_full(input int unsigned count, input int unsigned queue_size);
        return count == queue_size;
    endfunction

endpackage

// File: rtl/mq_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for one logical queue; storage lives in the top.
module mq_fifo_ctrl
    import mq_fifo_pkg::*;
#(
    parameter int unsigned QUEUE_SIZE   = 16,
    parameter int unsigned AFULL_THRESH = QUEUE_SIZE - 2,
    localparam int unsigned PW = calc_pw(QUEUE_SIZE),
    localparam int unsigned CW = calc_cw(QUEUE_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc_tail,
    input  logic          i_inc_head,
    input  logic          i_flush,
    output logic [PW-1:0] o_head,
    output logic [PW-1:0] o_tail,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_afull,
    output logic [CW-1:0] o_count
);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [PW-1:0] w_head_nxt;
    logic [PW-1:0] w_tail_nxt;
    logic [CW-1:0] w_count_nxt;

    // Flush wins over any same-cycle increment; the top already masks those, this is belt-and-braces.
    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (i_flush) begin
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            if (i_inc_tail) begin
                w_tail_nxt = r_tail + 1'b1;
            end
            if (i_inc_head) begin
                w_head_nxt = r_head + 1'b1;
            end
            case ({i_inc_tail, i_inc_head})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        o_head  = r_head;
        o_tail  = r_tail;
        o_count = r_count;
        o_empty = (r_count == '0);
        o_full  = is_full(32'(r_count), QUEUE_SIZE);
        o_afull = thresh_reached(32'(r_count), AFULL_THRESH);
    end

endmodule

// File: rtl/multi_queue_fifo.sv
// NUM_QUEUES independent FIFOs sharing one storage array, addressed as {qid, ptr}.
module multi_queue_fifo
    import mq_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned QUEUE_SIZE   = 16,
    parameter int unsigned NUM_QUEUES   = 4,
    parameter int unsigned AFULL_THRESH = QUEUE_SIZE - 2,
    localparam int unsigned QW = calc_qw(NUM_QUEUES),
    localparam int unsigned PW = calc_pw(QUEUE_SIZE),
    localparam int unsigned CW = calc_cw(QUEUE_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enq_en,
    input  logic [QW-1:0]            i_enq_qid,
    input  logic [DWIDTH-1:0]        i_enq_data,
    output logic                     o_enq_ready,
    input  logic                     i_deq_en,
    input  logic [QW-1:0]            i_deq_qid,
    output logic                     o_deq_valid,
    output logic [DWIDTH-1:0]        o_deq_data,
    input  logic                     i_flush_en,
    input  logic [QW-1:0]            i_flush_qid,
    output logic [NUM_QUEUES-1:0]    o_q_empty,
    output logic [NUM_QUEUES-1:0]    o_q_full,
    output logic [NUM_QUEUES-1:0]    o_q_afull,
    output logic [NUM_QUEUES*CW-1:0] o_q_count
);

    localparam int unsigned Depth = NUM_QUEUES * QUEUE_SIZE;
    localparam int unsigned AW    = QW + PW;

    logic [DWIDTH-1:0] r_mem [Depth];

    logic [PW-1:0]         w_head  [NUM_QUEUES];
    logic [PW-1:0]         w_tail  [NUM_QUEUES];
    logic [CW-1:0]         w_count [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] w_empty;
    logic [NUM_QUEUES-1:0] w_full;
    logic [NUM_QUEUES-1:0] w_afull;
    logic [NUM_QUEUES-1:0] w_inc_tail;
    logic [NUM_QUEUES-1:0] w_inc_head;
    logic [NUM_QUEUES-1:0] w_flush;

    logic          w_enq_ready;
    logic          w_deq_valid;
    logic [PW-1:0] w_enq_tail;
    logic [PW-1:0] w_deq_head;
    logic          w_enq_fire;
    logic          w_deq_fire;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;

    // Qid steering by comparison against each queue index, so out-of-range ids match nothing.
    always_comb begin
        w_enq_ready = 1'b0;
        w_deq_valid = 1'b0;
        w_enq_tail  = '0;
        w_deq_head  = '0;
        w_flush     = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (i_enq_qid == QW'(i)) begin
                w_enq_ready = !w_full[i];
                w_enq_tail  = w_tail[i];
            end
            if (i_deq_qid == QW'(i)) begin
                w_deq_valid = !w_empty[i];
                w_deq_head  = w_head[i];
            end
            w_flush[i] = i_flush_en && (i_flush_qid == QW'(i));
        end
    end

    // A flush of the same queue drops the enqueue/dequeue entirely.
    assign w_enq_fire = i_enq_en && w_enq_ready && !(i_flush_en && (i_flush_qid == i_enq_qid));
    assign w_deq_fire = i_deq_en && w_deq_valid && !(i_flush_en && (i_flush_qid == i_deq_qid));
    assign w_wr_addr  = {i_enq_qid, w_enq_tail};
    assign w_rd_addr  = {i_deq_qid, w_deq_head};

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
        assign w_inc_tail[g] = w_enq_fire && (i_enq_qid == QW'(g));
        assign w_inc_head[g] = w_deq_fire && (i_deq_qid == QW'(g));

        mq_fifo_ctrl #(
            .QUEUE_SIZE   (QUEUE_SIZE),
            .AFULL_THRESH (AFULL_THRESH)
        ) u_ctrl (
            .clk        (clk),
            .rst        (rst),
            .i_inc_tail (w_inc_tail[g]),
            .i_inc_head (w_inc_head[g]),
            .i_flush    (w_flush[g]),
            .o_head     (w_head[g]),
            .o_tail     (w_tail[g]),
            .o_empty    (w_empty[g]),
            .o_full     (w_full[g]),
            .o_afull    (w_afull[g]),
            .o_count    (w_count[g])
        );

        assign o_q_count[g*CW +: CW] = w_count[g];
    end

    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_mem[w_wr_addr] <= i_enq_data;
        end
    end

    always_comb begin
        o_enq_ready = w_enq_ready;
        o_deq_valid = w_deq_valid;
        o_deq_data  = w_deq_valid ? r_mem[w_rd_addr] : '0;
        o_q_empty   = w_empty;
        o_q_full    = w_full;
        o_q_afull   = w_afull;
    end

endmodule

// File: tb/tb_multi_queue_fifo.sv
// Randomised bench for multi_queue_fifo against a queue-of-queues reference model.
module tb_multi_queue_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned QS = 16;
    localparam int unsigned NQ = 4;
    localparam int unsigned CW = 5;
    localparam int unsigned QW = 2;
    localparam int unsigned AF = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             enq_en, deq_en, flush_en;
    logic [QW-1:0]    enq_qid, deq_qid, flush_qid;
    logic [DW-1:0]    enq_data;
    logic             enq_ready, deq_valid;
    logic [DW-1:0]    deq_data;
    logic [NQ-1:0]    q_empty, q_full, q_afull;
    logic [NQ*CW-1:0] q_count;

    // Second instance with a non-power-of-two queue count for out-of-range ids.
    logic           s_enq_en, s_deq_en, s_flush_en;
    logic [1:0]     s_enq_qid, s_deq_qid, s_flush_qid;
    logic [DW-1:0]  s_enq_data;
    logic           s_enq_ready, s_deq_valid;
    logic [DW-1:0]  s_deq_data;
    logic [2:0]     s_q_empty, s_q_full, s_q_afull;
    logic [3*CW-1:0] s_q_count;

    multi_queue_fifo #(
        .DWIDTH     (DW),
        .QUEUE_SIZE (QS),
        .NUM_QUEUES (NQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_enq_en    (enq_en),
        .i_enq_qid   (enq_qid),
        .i_enq_data  (enq_data),
        .o_enq_ready (enq_ready),
        .i_deq_en    (deq_en),
        .i_deq_qid   (deq_qid),
        .o_deq_valid (deq_valid),
        .o_deq_data  (deq_data),
        .i_flush_en  (flush_en),
        .i_flush_qid (flush_qid),
        .o_q_empty   (q_empty),
        .o_q_full    (q_full),
        .o_q_afull   (q_afull),
        .o_q_count   (q_count)
    );

    multi_queue_fifo #(
        .DWIDTH     (DW),
        .QUEUE_SIZE (QS),
        .NUM_QUEUES (3)
    ) dut3 (
        .clk         (clk),
        .rst         (rst),
        .i_enq_en    (s_enq_en),
        .i_enq_qid   (s_enq_qid),
        .i_enq_data  (s_enq_data),
        .o_enq_ready (s_enq_ready),
        .i_deq_en    (s_deq_en),
        .i_deq_qid   (s_deq_qid),
        .o_deq_valid (s_deq_valid),
        .o_deq_data  (s_deq_data),
        .i_flush_en  (s_flush_en),
        .i_flush_qid (s_flush_qid),
        .o_q_empty   (s_q_empty),
        .o_q_full    (s_q_full),
        .o_q_afull   (s_q_afull),
        .o_q_count   (s_q_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [DW-1:0] mq [NQ][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one FIFO per queue, updated with the same rules as the hardware contract.
    always @(posedge clk or posedge rst) begin
        bit efire, dfire;
        if (rst) begin
            for (int q = 0; q < NQ; q++) mq[q].delete();
        end else begin
            efire = enq_en && (mq[enq_qid].size() < QS) && !(flush_en && flush_qid == enq_qid);
            dfire = deq_en && (mq[deq_qid].size() > 0) && !(flush_en && flush_qid == deq_qid);
            if (dfire) void'(mq[deq_qid].pop_front());
            if (efire) mq[enq_qid].push_back(enq_data);
            if (flush_en) mq[flush_qid].delete();
        end
    end

    always @(negedge clk) begin
        logic [NQ-1:0]    e_empty, e_full, e_afull;
        logic [NQ*CW-1:0] e_count;
        logic [DW-1:0]    e_data;
        int               sz;
        if (chk_en) begin
            for (int q = 0; q < NQ; q++) begin
                sz = mq[q].size();
                e_empty[q] = (sz == 0);
                e_full[q]  = (sz == QS);
                e_afull[q] = (sz >= AF);
                e_count[q*CW +: CW] = CW'(sz);
            end
            check("q_empty", q_empty, e_empty);
            check("q_full", q_full, e_full);
            check("q_afull", q_afull, e_afull);
            check("q_count", q_count, e_count);
            check("enq_ready", enq_ready, mq[enq_qid].size() < QS);
            check("deq_valid", deq_valid, mq[deq_qid].size() != 0);
            e_data = '0;
            if (mq[deq_qid].size() != 0) e_data = mq[deq_qid][0];
            check("deq_data", deq_data, e_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {enq_en, deq_en, flush_en} = '0;
        {enq_qid, deq_qid, flush_qid} = '0;
        enq_data = '0;
        {s_enq_en, s_deq_en, s_flush_en} = '0;
        {s_enq_qid, s_deq_qid, s_flush_qid} = '0;
        s_enq_data = '0;
        chk_en = 1'b1;

        @(negedge clk);
        check("rst_empty", q_empty, 4'hF);
        check("rst_full", q_full, 4'h0);
        check("rst_afull", q_afull, 4'h0);
        check("rst_count", q_count, 20'h0);
        check("rst_enq_ready", enq_ready, 1'b1);
        check("rst_deq_valid", deq_valid, 1'b0);
        check("rst_deq_data", deq_data, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Out-of-range ids on the 3-queue instance.
        s_enq_en = 1'b1; s_enq_qid = 2'd0; s_enq_data = 32'h55;
        tick();
        s_enq_qid = 2'd3; s_enq_data = 32'hDEAD;
        s_deq_en = 1'b1; s_deq_qid = 2'd3;
        s_flush_en = 1'b1; s_flush_qid = 2'd3;
        @(negedge clk);
        check("oor_enq_ready", s_enq_ready, 1'b0);
        check("oor_deq_valid", s_deq_valid, 1'b0);
        check("oor_deq_data", s_deq_data, 32'h0);
        tick();
        {s_enq_en, s_deq_en, s_flush_en} = '0;
        @(negedge clk);
        check("oor_count", s_q_count, 15'd1);
        check("oor_empty", s_q_empty, 3'b110);
        check("oor_full", s_q_full, 3'b000);
        s_deq_qid = 2'd0;
        #1;
        check("oor_q0_valid", s_deq_valid, 1'b1);
        check("oor_q0_data", s_deq_data, 32'h55);

        // Fill queue 2 to capacity, then offer a 17th word.
        tick();
        enq_en = 1'b1; enq_qid = 2'd2;
        for (int i = 0; i < 16; i++) begin
            enq_data = 32'hA0 + i;
            tick();
        end
        enq_data = 32'hB0;
        @(negedge clk);
        check("fill_count2", q_count[2*CW +: CW], 5'd16);
        check("fill_full2", q_full[2], 1'b1);
        check("fill_ready", enq_ready, 1'b0);
        check("fill_empty", q_empty, 4'b1011);
        tick();
        enq_en = 1'b0;

        deq_en = 1'b1; deq_qid = 2'd2;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("drain_data", deq_data, 32'hA0 + i);
            tick();
        end
        @(negedge clk);
        check("drain_empty2", q_empty[2], 1'b1);
        check("drain_valid", deq_valid, 1'b0);
        tick();
        deq_en = 1'b0;

        // Interleaved traffic on queues 0 and 1 with pointer wrap.
        enq_en = 1'b1; enq_qid = 2'd1;
        for (int i = 0; i < 8; i++) begin
            enq_data = $urandom;
            tick();
        end
        deq_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            enq_qid  = (c % 2 == 0) ? 2'd0 : 2'd1;
            deq_qid  = (c % 2 == 0) ? 2'd1 : 2'd0;
            enq_data = $urandom;
            tick();
        end
        {enq_en, deq_en} = '0;

        // Queue 3: simultaneous enq+deq, then flush racing an enqueue.
        enq_en = 1'b1; enq_qid = 2'd3;
        for (int i = 0; i < 5; i++) begin
            enq_data = 32'hC0 + i;
            tick();
        end
        enq_data = 32'hD0; deq_en = 1'b1; deq_qid = 2'd3;
        tick();
        {enq_en, deq_en} = '0;
        @(negedge clk);
        check("q3_count_5", q_count[3*CW +: CW], 5'd5);
        check("q3_head", deq_data, 32'hC1);
        tick();
        enq_en = 1'b1; enq_data = 32'hE0; flush_en = 1'b1; flush_qid = 2'd3;
        tick();
        {enq_en, flush_en} = '0;
        @(negedge clk);
        check("q3_flush_count", q_count[3*CW +: CW], 5'd0);
        check("q3_flush_valid", deq_valid, 1'b0);
        tick();

        // Random traffic, alternating drain-heavy and fill-heavy stretches.
        for (int c = 0; c < 1500; c++) begin
            enq_en    = ($urandom_range(0, 3) != 0);
            enq_qid   = QW'($urandom_range(0, 3));
            enq_data  = $urandom;
            deq_en    = ($urandom_range(0, 9) < (((c / 200) % 2 == 1) ? 8 : 4));
            deq_qid   = QW'($urandom_range(0, 3));
            flush_en  = ($urandom_range(0, 39) == 0);
            flush_qid = QW'($urandom_range(0, 3));
            tick();
        end

        // Asynchronous reset in the middle of a burst.
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_empty", q_empty, 4'hF);
        check("mid_rst_count", q_count, 20'h0);
        check("mid_rst_full", q_full, 4'h0);
        check("mid_rst_valid", deq_valid, 1'b0);
        check("mid_rst_data", deq_data, 32'h0);
        check("mid_rst_ready", enq_ready, 1'b1);
        {enq_en, deq_en, flush_en} = '0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();
        enq_en = 1'b1; enq_qid = 2'd1; enq_data = 32'h1234_5678;
        tick();
        enq_en = 1'b0; deq_en = 1'b1; deq_qid = 2'd1;
        @(negedge clk);
        check("post_rst_data", deq_data, 32'h1234_5678);
        check("post_rst_count1", q_count[1*CW +: CW], 5'd1);
        tick();
        deq_en = 1'b0;
        @(negedge clk);
        check("post_rst_empty", q_empty, 4'hF);

        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_queue_fifo.md
# multi_queue_fifo

Parametrised multi-channel FIFO: NUM_QUEUES independent logical queues sharing one storage array, each QUEUE_SIZE entries deep with full usable capacity, per-queue occupancy/status and per-queue flush. Successor to the single-queue ring buffer in the data-structure library; feeds per-class/per-flow buffering ahead of schedulers. Single enqueue port and single dequeue port, each steered by a queue id.

## Interface
- DWIDTH, 32, data width in bits.
- QUEUE_SIZE, 16, entries per queue; power of two, ≥2.
- NUM_QUEUES, 4, number of logical queues; ≥1, any value.
- AFULL_THRESH, QUEUE_SIZE-2, q_afull asserts when count ≥ this value.
- Derived: QW = max(1,$clog2(NUM_QUEUES)); PW = $clog2(QUEUE_SIZE); CW = PW+1.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- enq_en  in  1  enqueue request.
- enq_qid  in  QW  target queue for enqueue.
- enq_data  in  DWIDTH  enqueue payload.
- enq_ready  out  1  target queue accepts (not full, qid in range).
- deq_en  in  1  dequeue request.
- deq_qid  in  QW  source queue for dequeue.
- deq_valid  out  1  source queue non-empty, qid in range.
- deq_data  out  DWIDTH  head entry of deq_qid (first-word fall-through).
- flush_en  in  1  discard all entries of flush_qid.
- flush_qid  in  QW  queue to flush.
- q_empty  out  NUM_QUEUES  per-queue empty.
- q_full  out  NUM_QUEUES  per-queue full (count == QUEUE_SIZE).
- q_afull  out  NUM_QUEUES  per-queue almost full.
- q_count  out  NUM_QUEUES*CW  per-queue occupancy, queue i at bits [i*CW +: CW].

## Operation
- Per queue: head/tail pointers (PW bits, natural wrap at QUEUE_SIZE) plus CW-bit count; full/empty from count, so all QUEUE_SIZE slots usable.
- Storage: NUM_QUEUES*QUEUE_SIZE words, address {qid, ptr}; not reset.
- Enqueue fires when enq_en && enq_ready: write enq_data at tail, tail+1, count+1.
- Dequeue fires when deq_en && deq_valid: head+1, count-1.
- enq_ready = !q_full[enq_qid] && enq_qid < NUM_QUEUES; no bypass via same-cycle dequeue of a full queue.
- deq_valid = !q_empty[deq_qid] && deq_qid < NUM_QUEUES; no bypass via same-cycle enqueue of an empty queue.
- deq_data = storage[{deq_qid, head}] when deq_valid, else all zeros.
- Enqueue and dequeue on same non-full, non-empty queue same cycle: both fire, count unchanged.
- Different queues same cycle: fully independent.
- Flush: head, tail, count of flush_qid cleared to 0 at next edge; overrides enqueue and/or dequeue to that queue in the same cycle (both dropped, no pointer change). Enq/deq to other queues proceed. Out-of-range flush_qid ignored.
- enq_en/deq_en to out-of-range qid: no state change.

## Timing
- enq_ready, deq_valid, deq_data: combinational from qid inputs and registered state, zero-latency.
- Enqueued word visible at deq_data the cycle after the enqueue edge (1-cycle write-to-read latency).
- Status outputs (q_empty, q_full, q_afull, q_count) update on the edge following the firing event; registered-state derived.
- Reset (asynchronous, any time incl. mid-burst): all pointers/counts 0; q_empty all 1; q_full, q_afull all 0 (q_afull 1 only if AFULL_THRESH==0); q_count 0; enq_ready 1 for in-range enq_qid; deq_valid 0; deq_data 0.

## Structure
- Package mq_fifo_pkg: function for QW/CW derivation and status-vector helpers; no queue-specific typedefs beyond a count type parameterised by CW.
- Sub-module mq_fifo_ctrl: one per queue (generate loop), holding head/tail/count with inc_tail, inc_head, flush inputs and empty/full/afull/count outputs. Top holds storage array and qid steering.

## Test plan
- Reset, then enqueue 0xA0..0xAF into queue 2 (QUEUE_SIZE=16) -> 16 accepted, q_full[2]=1, enq_ready=0 on 17th, q_count[2]=16, other queues empty.
- Drain queue 2 -> deq_data 0xA0..0xAF in order, q_empty[2]=1 after 16th, deq_valid=0.
- Interleave: enqueue queue 0 and dequeue queue 1 same cycle over 40 cycles with wrap -> per-queue order preserved, no cross-queue corruption.
- Queue 3 holding 5 entries; simultaneous enq+deq on queue 3 -> count stays 5; then flush queue 3 with enq_en to queue 3 same cycle -> count 0, enqueued word dropped.
- NUM_QUEUES=3, enq_qid=3 and deq_qid=3 -> enq_ready=0, deq_valid=0, deq_data=0, no state change.
- Assert rst with queues partially full mid-burst -> all outputs at reset values in same cycle, subsequent first enqueue returns correct data.
